// File: rtl/bit_serial_div.sv
// Multi-cycle signed divider: one restoring-division quotient bit per clock on operand magnitudes.
// Optional macro DIV_ERROR_FLAGS_EN adds an `error` output flagging divide-by-zero and overflow.
module bit_serial_div #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] in_n,
   input  logic signed [WIDTH-1:0] in_d,
   input  logic                    start,
   output logic signed [WIDTH-1:0] quotient,
   output logic signed [WIDTH-1:0] remainder,
   output logic                    finished
`ifdef DIV_ERROR_FLAGS_EN
   ,
   output logic                    error
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] NEG_ONE = {WIDTH{1'b1}};

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [WIDTH-1:0]        qmag;
   logic [WIDTH-1:0]        dmag;
   logic [WIDTH-1:0]        prem;
   logic signed [WIDTH-1:0] n_orig;
   logic                    sign_q;
   logic                    sign_r;
   logic                    dz;
   logic                    ov;
   logic [WIDTH:0]          prem_sh;
   logic [WIDTH:0]          trial;

   // |MIN| wraps to the same bit pattern, which is the correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
      logic [WIDTH-1:0] u;
      u = v;
      return v[WIDTH-1] ? (~u + ONE) : u;
   endfunction

   function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                          input logic neg);
      return neg ? signed'(~mag + ONE) : signed'(mag);
   endfunction

   function automatic logic signed [WIDTH-1:0] fix_quotient(input logic [WIDTH-1:0] qm,
                                                            input logic neg,
                                                            input logic is_dz,
                                                            input logic is_ov,
                                                            input logic signed [WIDTH-1:0] n);
      if (is_dz)
         return n[WIDTH-1] ? MIN_V : MAX_V;
      else if (is_ov)
         return MAX_V;
      else
         return apply_sign(qm, neg);
   endfunction

   function automatic logic signed [WIDTH-1:0] fix_remainder(input logic [WIDTH-1:0] rm,
                                                             input logic neg,
                                                             input logic is_dz,
                                                             input logic is_ov,
                                                             input logic signed [WIDTH-1:0] n);
      if (is_dz)
         return n;
      else if (is_ov)
         return '0;
      else
         return apply_sign(rm, neg);
   endfunction

   // The shifted partial remainder needs WIDTH+1 bits; the kept value always fits WIDTH.
   always_comb begin
      prem_sh = {prem, qmag[WIDTH-1]};
      trial   = prem_sh - {1'b0, dmag};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
         finished  <= 1'b1;
`ifdef DIV_ERROR_FLAGS_EN
         error     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  qmag     <= abs_mag(in_n);
                  dmag     <= abs_mag(in_d);
                  n_orig   <= in_n;
                  sign_q   <= in_n[WIDTH-1] ^ in_d[WIDTH-1];
                  sign_r   <= in_n[WIDTH-1];
                  dz       <= (in_d == '0);
                  ov       <= (in_n == MIN_V) && (in_d == NEG_ONE);
                  prem     <= '0;
                  cnt      <= '0;
                  finished <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (!trial[WIDTH]) begin
                  prem <= trial[WIDTH-1:0];
                  qmag <= {qmag[WIDTH-2:0], 1'b1};
               end else begin
                  prem <= prem_sh[WIDTH-1:0];
                  qmag <= {qmag[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + CNT_ONE;
               if (cnt == CNT_LAST)
                  state <= FIX;
            end
            FIX: begin
               quotient  <= fix_quotient(qmag, sign_q, dz, ov, n_orig);
               remainder <= fix_remainder(prem, sign_r, dz, ov, n_orig);
`ifdef DIV_ERROR_FLAGS_EN
               error     <= dz | ov;
`endif
               finished  <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               finished <= 1'b1;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_div.sv
// Directed bench for bit_serial_div (WIDTH=8): vector table, busy/reset sequences, held-start sweep.
module tb_bit_serial_div;

   localparam int W = 8;

   logic                clk;
   logic                rst;
   logic signed [W-1:0] in_n;
   logic signed [W-1:0] in_d;
   logic                start;
   logic signed [W-1:0] quotient;
   logic signed [W-1:0] remainder;
   logic                finished;
`ifdef DIV_ERROR_FLAGS_EN
   logic                error;
`endif

   bit_serial_div #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_n      (in_n),
      .in_d      (in_d),
      .start     (start),
      .quotient  (quotient),
      .remainder (remainder),
      .finished  (finished)
`ifdef DIV_ERROR_FLAGS_EN
      ,
      .error     (error)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic signed [W-1:0] n;
      logic signed [W-1:0] d;
      logic signed [W-1:0] q;
      logic signed [W-1:0] r;
      logic                e;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic ref_div(input logic signed [W-1:0] n, input logic signed [W-1:0] d,
                          output int q, output int r);
      int ni;
      int di;
      ni = n;
      di = d;
      if (di == 0) begin
         q = (ni >= 0) ? 127 : -128;
         r = ni;
      end else if (ni == -128 && di == -1) begin
         q = 127;
         r = 0;
      end else begin
         q = ni / di;
         r = ni % di;
      end
   endtask

   // Drive one start pulse on the falling edge; c0 marks the cycle count before the accepting edge.
   task automatic start_op(input logic signed [W-1:0] n, input logic signed [W-1:0] d,
                           output int c0);
      in_n  = n;
      in_d  = d;
      start = 1'b1;
      c0    = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int low);
      int k;
      int c_start;
      c_start = cyc;
      k = 0;
      while (!finished && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!finished) chk("done_timeout", finished, 1);
      low = cyc - c_start;
   endtask

   initial begin
      int c0;
      int low;
      int q_ref;
      int r_ref;
      int falls;
      int prev_c0;
      logic prev_fin;
      logic signed [W-1:0] vals[14];
      logic signed [W-1:0] sn;
      logic signed [W-1:0] sd;

      vecs[0] = '{8'sd100,  8'sd7,    8'sd14,   8'sd2,   1'b0};
      vecs[1] = '{-8'sd100, 8'sd7,    -8'sd14,  -8'sd2,  1'b0};
      vecs[2] = '{8'sd100,  -8'sd7,   -8'sd14,  8'sd2,   1'b0};
      vecs[3] = '{-8'sd100, -8'sd7,   8'sd14,   -8'sd2,  1'b0};
      vecs[4] = '{8'sh80,   -8'sd1,   8'sd127,  8'sd0,   1'b1};
      vecs[5] = '{8'sd5,    8'sd0,    8'sd127,  8'sd5,   1'b1};
      vecs[6] = '{-8'sd5,   8'sd0,    8'sh80,   -8'sd5,  1'b1};
      vecs[7] = '{8'sh80,   8'sd1,    8'sh80,   8'sd0,   1'b0};
      vecs[8] = '{8'sd127,  8'sh80,   8'sd0,    8'sd127, 1'b0};
      vecs[9] = '{8'sh80,   8'sh80,   8'sd1,    8'sd0,   1'b0};

      rst   = 1'b1;
      start = 1'b0;
      in_n  = '0;
      in_d  = '0;
      repeat (3) @(negedge clk);
      chk("rst_finished", finished, 1);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
`ifdef DIV_ERROR_FLAGS_EN
      chk("rst_error", error, 0);
`endif
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].n, vecs[i].d, c0);
         chk($sformatf("v%0d_busy", i), finished, 0);
         wait_done(low);
         chk($sformatf("v%0d_latency", i), cyc - c0 - 1, W + 1);
         chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
         chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
`ifdef DIV_ERROR_FLAGS_EN
         chk($sformatf("v%0d_error", i), error, vecs[i].e);
`endif
      end

      // Start while busy is ignored; the previous result (1 r 0) stays visible during RUN.
      start_op(8'sd12, 8'sd5, c0);
      repeat (3) @(negedge clk);
      in_n  = 8'sd99;
      in_d  = 8'sd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_hold_quotient", quotient, 1);
      chk("busy_hold_remainder", remainder, 0);
      chk("busy_still_busy", finished, 0);
      wait_done(low);
      chk("busy_latency", cyc - c0 - 1, W + 1);
      chk("busy_quotient", quotient, 2);
      chk("busy_remainder", remainder, 2);
      falls = 0;
      prev_fin = finished;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (prev_fin && !finished) falls++;
         prev_fin = finished;
      end
      chk("busy_not_queued", falls, 0);

      // Reset in the middle of an operation discards it.
      start_op(8'sd100, 8'sd7, c0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_finished", finished, 1);
      chk("midrst_quotient", quotient, 0);
      chk("midrst_remainder", remainder, 0);
      start_op(8'sd100, 8'sd7, c0);
      wait_done(low);
      chk("after_rst_latency", cyc - c0 - 1, W + 1);
      chk("after_rst_quotient", quotient, 14);
      chk("after_rst_remainder", remainder, 2);

      // Held-start sweep: a new operation every W+2 cycles.
      vals = '{8'sh80, -8'sd127, -8'sd100, -8'sd7, -8'sd2, -8'sd1, 8'sd0,
               8'sd1, 8'sd2, 8'sd3, 8'sd7, 8'sd100, 8'sd126, 8'sd127};
      prev_c0 = -1;
      start = 1'b1;
      for (int p = 0; p < 296; p++) begin
         if (p < 196) begin
            sn = vals[p / 14];
            sd = vals[p % 14];
         end else begin
            sn = W'($urandom_range(0, 255));
            sd = W'($urandom_range(0, 255));
         end
         in_n = sn;
         in_d = sd;
         c0 = cyc;
         @(negedge clk);
         wait_done(low);
         ref_div(sn, sd, q_ref, r_ref);
         chk($sformatf("sweep_q %0d/%0d", sn, sd), quotient, q_ref);
         chk($sformatf("sweep_r %0d/%0d", sn, sd), remainder, r_ref);
         if (prev_c0 >= 0) chk("sweep_period", c0 - prev_c0, W + 2);
         prev_c0 = c0;
      end
      start = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
